// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: D = X - Y (mod 2^WIDTH), B = borrow (X < Y), LSB first.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E0+WIDTH.
// Backpressure: start is honoured only while ready=1; ignored while busy or done.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             xb;
    logic             yb;
    logic             db;
    logic             bo;
    logic             last;

    // One-bit subtractor cell fed from the operand LSBs and the running borrow
    always_comb begin
        xb   = x_sh[0];
        yb   = y_sh[0];
        db   = xb ^ yb ^ borrow;
        bo   = (~xb & yb) | (~(xb ^ yb) & borrow);
        last = (cnt == CW'(WIDTH - 1));
    end

    // Result shadow register takes each new difference bit at its MSB end
    if (WIDTH == 1) begin : g_w1
        assign r_nxt = db;
    end else begin : g_wn
        assign r_nxt = {db, r_sh[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; exactly one status flag per state
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per RUN cycle,
    // publish D/B only on the final bit so the ports hold the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sh   <= '0;
            y_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            D      <= '0;
            B      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_sh   <= X;
                        y_sh   <= Y;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    x_sh   <= x_sh >> 1;
                    y_sh   <= y_sh >> 1;
                    r_sh   <= r_nxt;
                    borrow <= bo;
                    if (last) begin
                        D <= r_nxt;
                        B <= bo;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 (directed + random), WIDTH=4 (exhaustive), WIDTH=1 (exhaustive).
// Expected {B,D} is computed arithmetically and queued on each accepted start; monitors pop on done.
// Monitors also track one-hot status, result hold between operations, and start-to-done latency.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // {borrow at bit w, difference mod 2^w}
    function automatic logic [63:0] ref_sub(input int w, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] m;
        logic [63:0] xm;
        logic [63:0] ym;
        logic [63:0] brw;
        m   = (64'd1 << w) - 64'd1;
        xm  = {32'd0, x} & m;
        ym  = {32'd0, y} & m;
        brw = (xm < ym) ? (64'd1 << w) : 64'd0;
        return brw | ((xm - ym) & m);
    endfunction

    // ---------------- WIDTH = 8 ----------------
    logic       rst8 = 1'b1, start8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0, d8;
    logic       ready8, busy8, done8, b8;
    logic [63:0] q8[$];
    int          t8[$];
    logic [63:0] held8 = '0;
    int          acc8 = 0, fin8 = 0;

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .X(x8), .Y(y8),
        .ready(ready8), .busy(busy8), .done(done8), .D(d8), .B(b8)
    );

    // ---------------- WIDTH = 4 ----------------
    logic       rst4 = 1'b1, start4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0, d4;
    logic       ready4, busy4, done4, b4;
    logic [63:0] q4[$];
    int          t4[$];
    logic [63:0] held4 = '0;
    int          acc4 = 0, fin4 = 0;

    serial_sub_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .X(x4), .Y(y4),
        .ready(ready4), .busy(busy4), .done(done4), .D(d4), .B(b4)
    );

    // ---------------- WIDTH = 1 ----------------
    logic       rst1 = 1'b1, start1 = 1'b0;
    logic [0:0] x1 = '0, y1 = '0, d1;
    logic       ready1, busy1, done1, b1;
    logic [63:0] q1[$];
    int          t1[$];
    logic [63:0] held1 = '0;
    int          acc1 = 0, fin1 = 0;

    serial_sub_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .X(x1), .Y(y1),
        .ready(ready1), .busy(busy1), .done(done1), .D(d1), .B(b1)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        int          t;
        if (rst8) begin
            q8.delete(); t8.delete(); held8 = '0;
        end else begin
            chk("onehot8", 64'(ready8) + 64'(busy8) + 64'(done8), 64'd1);
            if (done8) begin
                if (q8.size() == 0) chk("spurious_done8", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front(); t = t8.pop_front();
                    chk("result8", 64'({b8, d8}), e);
                    chk("latency8", 64'(cyc - t), 64'd9);
                    held8 = e; fin8++;
                end
            end else chk("hold8", 64'({b8, d8}), held8);
            if (ready8 && start8) begin
                q8.push_back(ref_sub(8, 32'(x8), 32'(y8))); t8.push_back(cyc); acc8++;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        int          t;
        if (rst4) begin
            q4.delete(); t4.delete(); held4 = '0;
        end else begin
            chk("onehot4", 64'(ready4) + 64'(busy4) + 64'(done4), 64'd1);
            if (done4) begin
                if (q4.size() == 0) chk("spurious_done4", 64'd1, 64'd0);
                else begin
                    e = q4.pop_front(); t = t4.pop_front();
                    chk("result4", 64'({b4, d4}), e);
                    chk("latency4", 64'(cyc - t), 64'd5);
                    held4 = e; fin4++;
                end
            end else chk("hold4", 64'({b4, d4}), held4);
            if (ready4 && start4) begin
                q4.push_back(ref_sub(4, 32'(x4), 32'(y4))); t4.push_back(cyc); acc4++;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        int          t;
        if (rst1) begin
            q1.delete(); t1.delete(); held1 = '0;
        end else begin
            chk("onehot1", 64'(ready1) + 64'(busy1) + 64'(done1), 64'd1);
            if (done1) begin
                if (q1.size() == 0) chk("spurious_done1", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front(); t = t1.pop_front();
                    chk("result1", 64'({b1, d1}), e);
                    chk("latency1", 64'(cyc - t), 64'd2);
                    held1 = e; fin1++;
                end
            end else chk("hold1", 64'({b1, d1}), held1);
            if (ready1 && start1) begin
                q1.push_back(ref_sub(1, 32'(x1), 32'(y1))); t1.push_back(cyc); acc1++;
            end
        end
    end

    // ---------------- drivers ----------------
    // With junk=1 the 8 RUN cycles after acceptance carry random start/X/Y, all of which must be ignored
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit junk);
        int t = 0;
        while (!ready8 && t < 40) begin @(posedge clk); #1; t++; end
        chk("ready_wait8", 64'(ready8), 64'd1);
        x8 = x; y8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        if (junk) begin
            repeat (8) begin
                start8 = 1'($urandom_range(0, 1));
                x8 = 8'($urandom); y8 = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        start8 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        int t = 0;
        while (!ready4 && t < 40) begin @(posedge clk); #1; t++; end
        chk("ready_wait4", 64'(ready4), 64'd1);
        x4 = x; y4 = y; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic op1(input logic [0:0] x, input logic [0:0] y);
        int t = 0;
        while (!ready1 && t < 40) begin @(posedge clk); #1; t++; end
        chk("ready_wait1", 64'(ready1), 64'd1);
        x1 = x; y1 = y; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
        chk("rst_ready8", 64'(ready8), 64'd1);
        chk("rst_busy8",  64'(busy8),  64'd0);
        chk("rst_done8",  64'(done8),  64'd0);
        chk("rst_D8",     64'(d8),     64'd0);
        chk("rst_B8",     64'(b8),     64'd0);
        chk("rst_ready4", 64'(ready4), 64'd1);
        chk("rst_ready1", 64'(ready1), 64'd1);

        fork
            begin : drive8
                int t;
                int a0;
                op8(8'h5A, 8'h23, 1'b0);
                op8(8'h10, 8'h20, 1'b0);
                op8(8'hFF, 8'hFF, 1'b0);
                op8(8'h00, 8'h01, 1'b0);

                // start held through RUN/DONE, operands changed mid-op
                t = 0;
                while (!ready8 && t < 40) begin @(posedge clk); #1; t++; end
                a0 = acc8;
                x8 = 8'h5A; y8 = 8'h23; start8 = 1'b1;
                @(posedge clk); #1;
                repeat (3) begin @(posedge clk); #1; end
                x8 = 8'h00; y8 = 8'h00;
                t = 0;
                while (acc8 < a0 + 2 && t < 40) begin @(posedge clk); #1; t++; end
                chk("held_start_accepts", 64'(acc8 - a0), 64'd2);
                start8 = 1'b0;

                // reset on the 4th RUN cycle with a nonzero result held
                op8(8'h80, 8'h01, 1'b0);
                op8(8'hC3, 8'h5A, 1'b0);
                repeat (3) begin @(posedge clk); #1; end
                rst8 = 1'b1;
                @(posedge clk); #1;
                rst8 = 1'b0;
                chk("midrst_ready8", 64'(ready8), 64'd1);
                chk("midrst_busy8",  64'(busy8),  64'd0);
                chk("midrst_done8",  64'(done8),  64'd0);
                chk("midrst_D8",     64'(d8),     64'd0);
                chk("midrst_B8",     64'(b8),     64'd0);
                op8(8'h5A, 8'h23, 1'b0);

                op8(8'h00, 8'h00, 1'b0);
                op8(8'hFF, 8'h00, 1'b0);
                op8(8'h00, 8'hFF, 1'b0);
                repeat (40) begin
                    op8(8'($urandom), 8'($urandom), 1'b1);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin : drive4
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        op4(4'(x), 4'(y));
            end
            begin : drive1
                for (int x = 0; x < 2; x++)
                    for (int y = 0; y < 2; y++)
                        op1(1'(x), 1'(y));
            end
        join

        repeat (30) @(posedge clk);
        #1;
        chk("pending8", 64'(q8.size()), 64'd0);
        chk("pending4", 64'(q4.size()), 64'd0);
        chk("pending1", 64'(q1.size()), 64'd0);
        chk("finished8", 64'(fin8), 64'd51);
        chk("finished4", 64'(fin4), 64'd256);
        chk("finished1", 64'(fin1), 64'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
